// File: rtl/muldiv_if.sv
// Operand, request and write-back signals shared between the issue logic
// (master) and the iterative multiply/divide unit (slave).
interface muldiv_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      wa;
    logic            regWrite;

    modport master (
        output start, op, rs1, rs2, rd_addr,
        input  busy, done, result, wa, regWrite
    );

    modport slave (
        input  start, op, rs1, rs2, rd_addr,
        output busy, done, result, wa, regWrite
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit.
// Multiplication uses radix-2 shift-add and division uses restoring division.
// Both work on operand magnitudes and retire one bit per clock. The signs are
// applied in a single fix-up cycle before a one-cycle write-back strobe.
// Divide-by-zero and signed overflow finish straight from the accept edge.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [CW-1:0]     count;
    logic              neg_q;
    logic              neg_r;

    logic              signed_a;
    logic              signed_b;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_val;

    // Decode the incoming request: operand signedness, magnitudes and the
    // two division corner cases that bypass the iterative datapath.
    always_comb begin
        signed_a    = !(bus.op == OP_MULHU || bus.op == OP_DIVU || bus.op == OP_REMU);
        signed_b    = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                      (bus.op == OP_DIV) || (bus.op == OP_REM);
        sa          = signed_a && bus.rs1[XLEN-1];
        sb          = signed_b && bus.rs2[XLEN-1];
        mag_a       = sa ? (~bus.rs1 + 1'b1) : bus.rs1;
        mag_b       = sb ? (~bus.rs2 + 1'b1) : bus.rs2;
        div_zero    = bus.op[2] && (bus.rs2 == '0);
        div_ovf     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                      (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);
        special     = div_zero || div_ovf;
        special_val = '0;
        if (div_zero) begin
            special_val = bus.op[1] ? bus.rs1 : '1;
        end else if (div_ovf) begin
            special_val = bus.op[1] ? '0 : MIN_NEG;
        end
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_val;

    // One iteration step for each datapath plus the sign fix-up / output
    // select. For multiply, acc holds {partial product, remaining multiplier
    // bits}. For divide, acc holds {remainder, dividend/quotient bits}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        rem_sh   = acc[2*XLEN-1:XLEN-1];
        div_ge   = rem_sh >= {1'b0, mcand};
        div_diff = rem_sh[XLEN-1:0] - mcand;
        div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                          : {acc[2*XLEN-2:0], 1'b0};

        prod     = neg_q ? (~acc + 1'b1) : acc;
        fix_val  = '0;
        if (!op_q[2]) begin
            fix_val = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
            fix_val = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        end else begin
            fix_val = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        end
    end

    // Control FSM with registered handshake and write-back outputs.
    // A new request is also taken in DONE so back-to-back ops lose no cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= '0;
            acc          <= '0;
            mcand        <= '0;
            count        <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.regWrite <= 1'b0;
            bus.result   <= '0;
            bus.wa       <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.regWrite <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        bus.wa   <= bus.rd_addr;
                        count    <= '0;
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
                        bus.busy <= 1'b1;
                        if (special) begin
                            acc          <= '0;
                            mcand        <= '0;
                            bus.result   <= special_val;
                            bus.done     <= 1'b1;
                            bus.regWrite <= (bus.rd_addr != 5'd0);
                            state        <= DONE;
                        end else begin
                            if (bus.op[2]) begin
                                acc   <= {{XLEN{1'b0}}, mag_a};
                                mcand <= mag_b;
                            end else begin
                                acc   <= {{XLEN{1'b0}}, mag_b};
                                mcand <= mag_a;
                            end
                            state <= CALC;
                        end
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                CALC: begin
                    acc   <= op_q[2] ? div_next : mul_next;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.result   <= fix_val;
                    bus.done     <= 1'b1;
                    bus.regWrite <= (bus.wa != 5'd0);
                    state        <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for the iterative multiply/divide unit.
module tb_muldiv_unit;

    localparam int XLEN = 64;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts negedges from the cycle after the accept edge until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Issues one request, scrambles the inputs after acceptance, and returns
    // what was observed in the done cycle and in the cycle after it.
    task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, output int lat, output logic [63:0] res,
                          output logic [4:0] wa_o, output logic rw, output logic busy_o,
                          output logic done_next);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.rs1     = a;
        bus.rs2     = b;
        bus.rd_addr = rd;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = ~o;
        bus.rs1     = ~a;
        bus.rs2     = ~b;
        bus.rd_addr = ~rd;
        wait_done(lat);
        res    = bus.result;
        wa_o   = bus.wa;
        rw     = bus.regWrite;
        busy_o = bus.busy;
        @(negedge clk);
        done_next = bus.done;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.rs1     = '0;
        bus.rs2     = '0;
        bus.rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.regWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags busy=%b done=%b regWrite=%b expected 0 0 0",
                     bus.busy, bus.done, bus.regWrite);
        end
        checks++;
        if (bus.result !== 64'd0 || bus.wa !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_data result=%h wa=%0d expected 0 0", bus.result, bus.wa);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat; logic [63:0] res; logic [4:0] wa_o; logic rw, bz, dn;
        run_op(3'd0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd5, lat, res, wa_o, rw, bz, dn);
        checks++;
        if (lat != 65) begin
            failures++;
            $display("[TB] FAIL mul_latency got=%0d expected=65", lat);
        end
        checks++;
        if (res !== 64'hFFFFFFFFFFFFFFEB) begin
            failures++;
            $display("[TB] FAIL mul_result got=%h expected=FFFFFFFFFFFFFFEB", res);
        end
        checks++;
        if (wa_o !== 5'd5 || rw !== 1'b1 || bz !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mul_writeback wa=%0d regWrite=%b busy=%b expected 5 1 1", wa_o, rw, bz);
        end
        checks++;
        if (dn !== 1'b0 || bus.busy !== 1'b0 || bus.regWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mul_pulse done=%b busy=%b regWrite=%b expected 0 0 0",
                     dn, bus.busy, bus.regWrite);
        end
        run_op(3'd0, 64'h0000000123456789, 64'h10, 5'd6, lat, res, wa_o, rw, bz, dn);
        checks++;
        if (res !== 64'h0000001234567890) begin
            failures++;
            $display("[TB] FAIL mul_positive got=%h expected=0000001234567890", res);
        end
    endtask

    task automatic test_mul_high();
        int lat; logic [63:0] res; logic [4:0] wa_o; logic rw, bz, dn;
        logic [2:0] o; logic [63:0] a, b, e;
        for (int i = 0; i < 4; i++) begin
            a = 64'hFFFFFFFFFFFFFFFF;
            b = 64'hFFFFFFFFFFFFFFFF;
            case (i)
                0:       begin o = 3'd1; e = 64'h0; end
                1:       begin o = 3'd3; e = 64'hFFFFFFFFFFFFFFFE; end
                2:       begin o = 3'd2; e = 64'hFFFFFFFFFFFFFFFF; end
                default: begin o = 3'd3; a = 64'h8000000000000000; b = 64'd4; e = 64'd2; end
            endcase
            run_op(o, a, b, 5'd10, lat, res, wa_o, rw, bz, dn);
            checks++;
            if (res !== e || lat != 65) begin
                failures++;
                $display("[TB] FAIL mulh_case%0d got=%h lat=%0d expected=%h lat=65", i, res, lat, e);
            end
        end
    endtask

    task automatic test_div();
        int lat; logic [63:0] res; logic [4:0] wa_o; logic rw, bz, dn;
        logic [2:0] o; logic [63:0] a, b, e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin o = 3'd4; a = -64'sd7;   b = 64'd2; e = 64'hFFFFFFFFFFFFFFFD; end
                1:       begin o = 3'd6; a = -64'sd7;   b = 64'd2; e = 64'hFFFFFFFFFFFFFFFF; end
                2:       begin o = 3'd5; a = 64'd100;   b = 64'd7; e = 64'd14; end
                3:       begin o = 3'd7; a = 64'd100;   b = 64'd7; e = 64'd2; end
                default: begin o = 3'd6; a = 64'd100;   b = -64'sd7; e = 64'd2; end
            endcase
            run_op(o, a, b, 5'd12, lat, res, wa_o, rw, bz, dn);
            checks++;
            if (res !== e || lat != 65) begin
                failures++;
                $display("[TB] FAIL div_case%0d got=%h lat=%0d expected=%h lat=65", i, res, lat, e);
            end
        end
    endtask

    task automatic test_special();
        int lat; logic [63:0] res; logic [4:0] wa_o; logic rw, bz, dn;
        logic [2:0] o; logic [63:0] a, b, e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin o = 3'd4; a = 64'd55; b = 64'd0; e = 64'hFFFFFFFFFFFFFFFF; end
                1:       begin o = 3'd6; a = 64'd55; b = 64'd0; e = 64'd55; end
                2:       begin o = 3'd5; a = 64'd9;  b = 64'd0; e = 64'hFFFFFFFFFFFFFFFF; end
                3:       begin o = 3'd4; a = 64'h8000000000000000; b = 64'hFFFFFFFFFFFFFFFF;
                                 e = 64'h8000000000000000; end
                default: begin o = 3'd6; a = 64'h8000000000000000; b = 64'hFFFFFFFFFFFFFFFF;
                                 e = 64'd0; end
            endcase
            run_op(o, a, b, 5'd4, lat, res, wa_o, rw, bz, dn);
            checks++;
            if (res !== e || lat != 0 || rw !== 1'b1 || dn !== 1'b0) begin
                failures++;
                $display("[TB] FAIL special_case%0d got=%h lat=%0d regWrite=%b next_done=%b expected=%h lat=0 1 0",
                         i, res, lat, rw, dn, e);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int dones, first_lat; logic [63:0] res; logic [4:0] wa_o;
        int lat; logic rw, bz, dn;
        dones = 0; first_lat = -1; res = '0; wa_o = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.rs1 = 64'd6; bus.rs2 = 64'd7; bus.rd_addr = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 10 || c == 40) begin
                bus.start = 1'b1; bus.op = 3'd5; bus.rs1 = 64'd1000; bus.rs2 = 64'd10; bus.rd_addr = 5'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    first_lat = c;
                    res = bus.result;
                    wa_o = bus.wa;
                end
            end
        end
        checks++;
        if (dones != 1 || first_lat != 65) begin
            failures++;
            $display("[TB] FAIL busy_ignore dones=%0d lat=%0d expected 1 65", dones, first_lat);
        end
        checks++;
        if (res !== 64'd42 || wa_o !== 5'd3) begin
            failures++;
            $display("[TB] FAIL busy_result got=%h wa=%0d expected=2a wa=3", res, wa_o);
        end
        run_op(3'd5, 64'd9, 64'd3, 5'd0, lat, res, wa_o, rw, bz, dn);
        checks++;
        if (lat != 65 || res !== 64'd3 || rw !== 1'b0 || wa_o !== 5'd0) begin
            failures++;
            $display("[TB] FAIL rd_zero lat=%0d got=%h regWrite=%b wa=%0d expected 65 3 0 0",
                     lat, res, rw, wa_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.rs1 = 64'd9; bus.rs2 = 64'd9; bus.rd_addr = 5'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != 65 || bus.result !== 64'd81) begin
            failures++;
            $display("[TB] FAIL b2b_first lat=%0d got=%h expected 65 51", lat, bus.result);
        end
        bus.start = 1'b1; bus.op = 3'd4; bus.rs1 = -64'sd100; bus.rs2 = 64'd7; bus.rd_addr = 5'd2;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_accept busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        wait_done(lat);
        checks++;
        if (lat != 65 || bus.result !== 64'hFFFFFFFFFFFFFFF2 || bus.wa !== 5'd2) begin
            failures++;
            $display("[TB] FAIL b2b_second lat=%0d got=%h wa=%0d expected 65 FFFFFFFFFFFFFFF2 2",
                     lat, bus.result, bus.wa);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        int dones, lat; logic [63:0] res; logic [4:0] wa_o; logic rw, bz, dn;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd3; bus.rs1 = 64'd123; bus.rs2 = 64'd456; bus.rd_addr = 5'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'd0) begin
            failures++;
            $display("[TB] FAIL async_reset busy=%b done=%b result=%h expected 0 0 0",
                     bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("[TB] FAIL reset_no_done dones=%0d expected 0", dones);
        end
        run_op(3'd5, 64'd100, 64'd7, 5'd9, lat, res, wa_o, rw, bz, dn);
        checks++;
        if (lat != 65 || res !== 64'd14 || wa_o !== 5'd9 || rw !== 1'b1) begin
            failures++;
            $display("[TB] FAIL after_reset lat=%0d got=%h wa=%0d regWrite=%b expected 65 e 9 1",
                     lat, res, wa_o, rw);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
